// File: rtl/decode_stage.sv
// decode_stage: instruction decode with load-use bubble insertion; registered outputs form the ID/EX latch.
module decode_stage #(
    parameter logic [3:0] LW_OP = 4'h5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr_in,
    input  logic             instr_valid,
    input  logic             flush,
    output logic             stall,
    output logic [15:0]      reg1,
    output logic [15:0]      reg2,
    output logic [15:0]      write_code,
    output logic             w_flag,
    output logic [3:0]       opcode,
    output logic [15:0]      imm,
    output logic             id_valid,
    output logic             illegal,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef struct packed {
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [3:0]  wc;
        logic        wf;
        logic [3:0]  op;
        logic [15:0] imm;
        logic        vld;
        logic        ill;
    } lat_t;

    localparam lat_t BUBBLE = '{r1: 4'd0, r2: 4'd0, wc: 4'd0, wf: 1'b0, op: 4'hF,
                                imm: 16'd0, vld: 1'b0, ill: 1'b0};

    lat_t             dec, lat_d, lat_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [3:0]       op, rd, rs, rt;
    logic             use1, use2, hazard;

    assign op = instr_in[15:12];
    assign rd = instr_in[11:8];
    assign rs = instr_in[7:4];
    assign rt = instr_in[3:0];

    always_comb begin
        dec  = BUBBLE;
        dec.vld = 1'b1;
        use1 = 1'b0;
        use2 = 1'b0;
        if (op <= 4'h3) begin
            dec.r1 = rs;
            dec.r2 = rt;
            dec.wc = rd;
            dec.wf = 1'b1;
            dec.op = op;
            use1   = 1'b1;
            use2   = 1'b1;
        end else if (op == 4'h4 || op == 4'h5) begin
            dec.r1  = rs;
            dec.wc  = rd;
            dec.wf  = 1'b1;
            dec.op  = op;
            dec.imm = {{12{rt[3]}}, rt};
            use1    = 1'b1;
        end else if (op == 4'h6 || op == 4'h7) begin
            dec.r1  = rd;
            dec.r2  = rs;
            dec.op  = op;
            dec.imm = {{12{rt[3]}}, rt};
            use1    = 1'b1;
            use2    = 1'b1;
        end else if (op != 4'hF) begin
            dec.ill = 1'b1;
        end
        // r0 is hardwired zero, so a write to it is never enabled
        dec.wf = dec.wf & (dec.wc != 4'd0);
    end

    always_comb begin
        hazard = lat_q.vld && (lat_q.op == LW_OP) && (lat_q.wc != 4'd0) &&
                 ((use1 && dec.r1 == lat_q.wc) || (use2 && dec.r2 == lat_q.wc));
        stall  = ~rst & instr_valid & hazard & ~flush;
        lat_d  = (instr_valid && !flush && !stall) ? dec : BUBBLE;
        cnt_d  = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= BUBBLE;
            cnt_q <= '0;
        end else begin
            lat_q <= lat_d;
            cnt_q <= cnt_d;
        end
    end

    assign reg1       = {12'd0, lat_q.r1};
    assign reg2       = {12'd0, lat_q.r2};
    assign write_code = {12'd0, lat_q.wc};
    assign w_flag     = lat_q.wf;
    assign opcode     = lat_q.op;
    assign imm        = lat_q.imm;
    assign id_valid   = lat_q.vld;
    assign illegal    = lat_q.ill;
    assign bubble_cnt = cnt_q;
endmodule
